aud_play_ctrl: RTL

//   Playback sequencer in front of the audio DAC player. Accepts 16-bit samples from the

---
 rtl/aud_play_ctrl.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/aud_play_ctrl.sv
// aud_play_ctrl: playback sequencer between a sample source and the DAC player.
// Samples are buffered in a small FIFO. Player data and enable change only in the
// cycle after a DAC LR clock rising edge, so the left (low) half always sees a stable
// sample.
// Optional feature macro: AUD_UNDERRUN_CNT_EN adds o_underrun_cnt / o_underrun.
module aud_play_ctrl #(
   parameter int DATA_W  = 16,
   parameter int CNT_W   = 20,
   parameter int FIFO_AW = 1
) (
   input  logic              i_bclk,
   input  logic              i_rst_n,
   input  logic              i_daclrck,
   input  logic              i_start,
   input  logic              i_pause,
   input  logic              i_stop,
   input  logic [CNT_W-1:0]  i_len,
   input  logic              i_smp_valid,
   input  logic [DATA_W-1:0] i_smp_data,
   output logic              o_smp_ready,
   output logic [DATA_W-1:0] o_dac_data,
   output logic              o_en,
   output logic              o_busy,
   output logic              o_done,
   output logic [CNT_W-1:0]  o_smp_cnt
`ifdef AUD_UNDERRUN_CNT_EN
   ,
   output logic [15:0]       o_underrun_cnt,
   output logic              o_underrun
`endif
);

   localparam int                 DEPTH    = 2**FIFO_AW;
   localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW+1)'(DEPTH);
   localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW+1)'(1);
   localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_PLAY, S_PAUSE} state_t;

   state_t              r_state, w_state_nxt;
   logic                r_lrck_d;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [FIFO_AW-1:0]  r_wr_ptr, r_rd_ptr;
   logic [FIFO_AW:0]    r_level;
   logic [CNT_W-1:0]    r_len, r_req_cnt;
   logic                r_cur_valid, r_pause_pend, r_resume;

   logic                w_rise, w_empty, w_full, w_push, w_pop, w_flush, w_start_ok, w_underrun;
   logic                w_en_nxt, w_done_nxt, w_cv_nxt, w_pp_nxt, w_res_nxt;
   logic [DATA_W-1:0]   w_data_nxt, w_head;
   logic [CNT_W-1:0]    w_cnt_nxt, w_cnt_inc;
   logic [FIFO_AW:0]    w_lvl_nxt;

   assign w_rise      = ~r_lrck_d & i_daclrck;
   assign w_empty     = (r_level == '0);
   assign w_full      = (r_level == LVL_FULL);
   assign w_head      = r_mem[r_rd_ptr];
   assign o_busy      = (r_state != S_IDLE);
   assign o_smp_ready = ~w_full & (r_state != S_IDLE) & (r_req_cnt < r_len);
   assign w_push      = i_smp_valid & o_smp_ready;
   // The frame that just ended counts only if it carried a real sample.
   assign w_cnt_inc   = o_smp_cnt + (r_cur_valid ? CNT_ONE : '0);
   assign w_lvl_nxt   = r_level + (w_push ? LVL_ONE : '0) - (w_pop ? LVL_ONE : '0);

   // Next-state and next-output decisions; stop overrides every other command.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_flush     = 1'b0;
      w_en_nxt    = o_en;
      w_data_nxt  = o_dac_data;
      w_cnt_nxt   = o_smp_cnt;
      w_done_nxt  = 1'b0;
      w_cv_nxt    = r_cur_valid;
      w_pp_nxt    = r_pause_pend;
      w_res_nxt   = r_resume;
      w_start_ok  = 1'b0;
      w_underrun  = 1'b0;
      if (i_stop) begin
         w_state_nxt = S_IDLE;
         w_flush     = 1'b1;
         w_en_nxt    = 1'b0;
         w_data_nxt  = '0;
         w_cv_nxt    = 1'b0;
         w_pp_nxt    = 1'b0;
         w_res_nxt   = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start && (i_len != '0)) begin
                  w_start_ok  = 1'b1;
                  w_cnt_nxt   = '0;
                  w_cv_nxt    = 1'b0;
                  w_state_nxt = S_FILL;
               end
            end
            S_FILL: begin
               if (w_rise && !w_empty) begin
                  w_pop       = 1'b1;
                  w_data_nxt  = w_head;
                  w_en_nxt    = 1'b1;
                  w_cv_nxt    = 1'b1;
                  w_state_nxt = S_PLAY;
               end
            end
            S_PLAY: begin
               if (i_pause) w_pp_nxt = 1'b1;
               if (w_rise) begin
                  w_cnt_nxt = w_cnt_inc;
                  if (w_cnt_inc == r_len) begin
                     w_en_nxt    = 1'b0;
                     w_data_nxt  = '0;
                     w_done_nxt  = 1'b1;
                     w_cv_nxt    = 1'b0;
                     w_pp_nxt    = 1'b0;
                     w_state_nxt = S_IDLE;
                  end else if (r_pause_pend || i_pause) begin
                     // Prefetch the next sample so resume needs no extra frame.
                     w_en_nxt    = 1'b0;
                     w_pp_nxt    = 1'b0;
                     w_state_nxt = S_PAUSE;
                     w_pop       = ~w_empty;
                     w_data_nxt  = w_empty ? '0 : w_head;
                     w_cv_nxt    = ~w_empty;
                  end else if (!w_empty) begin
                     w_pop      = 1'b1;
                     w_data_nxt = w_head;
                     w_cv_nxt   = 1'b1;
                  end else begin
                     // Underrun: keep the player enabled but feed silence.
                     w_data_nxt = '0;
                     w_cv_nxt   = 1'b0;
                     w_underrun = 1'b1;
                  end
               end
            end
            S_PAUSE: begin
               if (i_start) w_res_nxt = 1'b1;
               if (w_rise && (r_resume || i_start)) begin
                  w_en_nxt    = 1'b1;
                  w_res_nxt   = 1'b0;
                  w_state_nxt = S_PLAY;
                  // The pause prefetch may have found the FIFO empty; retry now.
                  if (!r_cur_valid && !w_empty) begin
                     w_pop      = 1'b1;
                     w_data_nxt = w_head;
                     w_cv_nxt   = 1'b1;
                  end
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // State, player outputs and control flags.
   always_ff @(posedge i_bclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_lrck_d     <= 1'b0;
         o_en         <= 1'b0;
         o_dac_data   <= '0;
         o_done       <= 1'b0;
         o_smp_cnt    <= '0;
         r_cur_valid  <= 1'b0;
         r_pause_pend <= 1'b0;
         r_resume     <= 1'b0;
         r_len        <= '0;
         r_req_cnt    <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_lrck_d     <= i_daclrck;
         o_en         <= w_en_nxt;
         o_dac_data   <= w_data_nxt;
         o_done       <= w_done_nxt;
         o_smp_cnt    <= w_cnt_nxt;
         r_cur_valid  <= w_cv_nxt;
         r_pause_pend <= w_pp_nxt;
         r_resume     <= w_res_nxt;
         if (w_start_ok) begin
            r_len     <= i_len;
            r_req_cnt <= '0;
         end else if (w_push && !w_flush) begin
            r_req_cnt <= r_req_cnt + CNT_ONE;
         end
      end
   end

   // FIFO pointers and fill level; a flush on stop wins over any push/pop.
   always_ff @(posedge i_bclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (w_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         r_level <= w_lvl_nxt;
      end
   end

   // FIFO storage; contents are don't-care while the level is zero.
   always_ff @(posedge i_bclk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_smp_data;
   end

`ifdef AUD_UNDERRUN_CNT_EN
   // Underrun statistics, cleared by each accepted start.
   always_ff @(posedge i_bclk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_underrun_cnt <= '0;
         o_underrun     <= 1'b0;
      end else if (w_start_ok) begin
         o_underrun_cnt <= '0;
         o_underrun     <= 1'b0;
      end else if (w_underrun) begin
         if (o_underrun_cnt != 16'hFFFF) o_underrun_cnt <= o_underrun_cnt + 16'd1;
         o_underrun <= 1'b1;
      end
   end
`else
   logic w_unused_underrun;
   assign w_unused_underrun = w_underrun;
`endif

endmodule
